// File: rtl/bp_pkg.sv
// Shared branch-predictor definitions.
// Used by the resolve unit and the branch history table, so the index width
// default and the resolve FSM encoding stay consistent between them.
package bp_pkg;

  // Default predictor / history table index width
  localparam int LOWER_DEF = 5;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } bru_state_e;

  // Saturating 16-bit increment for the statistics counters
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/branch_inflight_fifo.sv
// In-flight prediction queue.
// Ports: clk, arst_n (async active-low); push/wdata enqueue, pop dequeues the
// oldest entry (rdata shows it combinationally), clr empties the queue and
// takes priority over push/pop. full/empty reflect the current occupancy.
// A push while full is accepted only together with a pop.
module branch_inflight_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 6
) (
  input  logic         clk,
  input  logic         arst_n,
  input  logic         push,
  input  logic         pop,
  input  logic         clr,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0]   cnt;
  logic          do_push, do_pop;

  assign full    = (cnt == (AW+1)'(DEPTH));
  assign empty   = (cnt == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rp];

  // Explicit wrap keeps the pointers modulo DEPTH for any DEPTH
  function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
    return (p == AW'(DEPTH-1)) ? '0 : p + AW'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (do_push && !clr) mem[wp] <= wdata;
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else if (clr) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (do_push) wp <= nxt(wp);
      if (do_pop)  rp <= nxt(rp);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + (AW+1)'(1);
        2'b01:   cnt <= cnt - (AW+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Branch resolve unit.
// Queues predictions issued by fetch (pred_*), pairs each with its resolution
// from execute (res_*), trains the history table (upd_*) one cycle after the
// pop and, on a mispredict, redirects fetch and flushes the younger stages
// for FLUSH_CYCLES cycles. en stalls everything. full/overflow/underflow report
// queue status; branch_cnt/mispredict_cnt are saturating statistics.
module branch_resolve_unit
  import bp_pkg::*;
#(
  parameter int LOWER        = LOWER_DEF,
  parameter int PC_W         = 32,
  parameter int DEPTH        = 4,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             en,
  input  logic             pred_valid,
  input  logic [LOWER-1:0] pred_addr,
  input  logic             pred_taken,
  input  logic             res_valid,
  input  logic             res_taken,
  input  logic             res_jump,
  input  logic [PC_W-1:0]  res_target,
  input  logic [PC_W-1:0]  res_next_pc,
  output logic             upd_en,
  output logic [LOWER-1:0] upd_addr,
  output logic             upd_taken,
  output logic             flush,
  output logic             redirect_valid,
  output logic [PC_W-1:0]  redirect_pc,
  output logic             full,
  output logic             overflow,
  output logic             underflow,
  output logic [15:0]      branch_cnt,
  output logic [15:0]      mispredict_cnt
);

  localparam int FCW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  bru_state_e     state;
  logic [FCW-1:0] fcnt;
  logic [LOWER:0] head;
  logic           empty, run, pop_fire, push_fire, actual, mis;

  assign run       = (state == ST_RUN);
  assign pop_fire  = en & run & res_valid & ~empty;
  // A push into a full queue is legal when the same cycle pops
  assign push_fire = en & run & pred_valid & (~full | pop_fire);
  assign actual    = res_taken | res_jump;
  assign mis       = pop_fire & (actual != head[0]);

  branch_inflight_fifo #(.DEPTH(DEPTH), .W(LOWER+1)) u_fifo (
    .clk    (clk),
    .arst_n (arst_n),
    .push   (push_fire),
    .pop    (pop_fire),
    .clr    (en & mis),
    .wdata  ({pred_addr, pred_taken}),
    .rdata  (head),
    .full   (full),
    .empty  (empty)
  );

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state          <= ST_RUN;
      fcnt           <= '0;
      flush          <= 1'b0;
      upd_en         <= 1'b0;
      upd_addr       <= '0;
      upd_taken      <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      overflow       <= 1'b0;
      underflow      <= 1'b0;
      branch_cnt     <= '0;
      mispredict_cnt <= '0;
    end else if (en) begin
      upd_en         <= pop_fire;
      redirect_valid <= mis;
      underflow      <= run & res_valid & empty;
      if (run && pred_valid && full && !pop_fire) overflow <= 1'b1;
      if (pop_fire) begin
        upd_addr    <= head[LOWER:1];
        upd_taken   <= actual;
        redirect_pc <= actual ? res_target : res_next_pc;
        branch_cnt  <= sat_inc16(branch_cnt);
        if (mis) mispredict_cnt <= sat_inc16(mispredict_cnt);
      end
      case (state)
        ST_RUN: if (mis) begin
          // flush rises together with redirect_valid
          state <= ST_FLUSH;
          flush <= 1'b1;
          fcnt  <= FCW'(FLUSH_CYCLES-1);
        end
        ST_FLUSH: if (fcnt == '0) begin
          state <= ST_RUN;
          flush <= 1'b0;
        end else begin
          fcnt <= fcnt - FCW'(1);
        end
        default: state <= ST_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_branch_resolve_unit.sv
module tb_branch_resolve_unit;

  localparam int LOWER = 5, PC_W = 32, DEPTH = 4, FC = 2;

  logic             clk = 1'b0, arst_n = 1'b0, en = 1'b0;
  logic             pred_valid = 1'b0, pred_taken = 1'b0;
  logic [LOWER-1:0] pred_addr = '0;
  logic             res_valid = 1'b0, res_taken = 1'b0, res_jump = 1'b0;
  logic [PC_W-1:0]  res_target = '0, res_next_pc = '0;
  logic             upd_en, upd_taken, flush, redirect_valid, full, overflow, underflow;
  logic [LOWER-1:0] upd_addr;
  logic [PC_W-1:0]  redirect_pc;
  logic [15:0]      branch_cnt, mispredict_cnt;

  branch_resolve_unit #(.LOWER(LOWER), .PC_W(PC_W), .DEPTH(DEPTH), .FLUSH_CYCLES(FC)) dut (
    .clk(clk), .arst_n(arst_n), .en(en),
    .pred_valid(pred_valid), .pred_addr(pred_addr), .pred_taken(pred_taken),
    .res_valid(res_valid), .res_taken(res_taken), .res_jump(res_jump),
    .res_target(res_target), .res_next_pc(res_next_pc),
    .upd_en(upd_en), .upd_addr(upd_addr), .upd_taken(upd_taken),
    .flush(flush), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .full(full), .overflow(overflow), .underflow(underflow),
    .branch_cnt(branch_cnt), .mispredict_cnt(mispredict_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  addr;
    logic        taken;
    logic        redir;
    logic [31:0] pc;
  } upd_t;

  upd_t       sb[$];        // expected history-table updates, oldest first
  logic [5:0] mq[$];        // model of the in-flight queue {addr, pred}
  int         fl;           // remaining flush-high cycles
  logic       m_ovf;
  int         m_bcnt, m_mcnt;
  int         checks = 0, errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    sb.delete(); mq.delete();
    fl = 0; m_ovf = 1'b0; m_bcnt = 0; m_mcnt = 0;
  endtask

  // One clock: drive inputs, predict, then compare just after the edge
  task automatic cyc(input logic e, input logic pv, input logic [4:0] pa, input logic pt,
                     input logic rv, input logic rt, input logic rj,
                     input logic [31:0] tgt, input logic [31:0] npc);
    logic exp_upd, exp_unf, popped, mis;
    logic [5:0] ent;
    int occ;
    upd_t u;
    en = e; pred_valid = pv; pred_addr = pa; pred_taken = pt;
    res_valid = rv; res_taken = rt; res_jump = rj; res_target = tgt; res_next_pc = npc;
    exp_upd = 1'b0; exp_unf = 1'b0; popped = 1'b0; mis = 1'b0;
    if (e && fl == 0) begin
      occ = mq.size();
      if (rv) begin
        if (occ == 0) exp_unf = 1'b1;
        else begin
          ent = mq.pop_front();
          popped = 1'b1;
          u.addr = ent[5:1];
          u.taken = rt | rj;
          mis = (u.taken != ent[0]);
          u.redir = mis;
          u.pc = u.taken ? tgt : npc;
          sb.push_back(u);
          exp_upd = 1'b1;
          if (m_bcnt < 16'hFFFF) m_bcnt++;
          if (mis && m_mcnt < 16'hFFFF) m_mcnt++;
        end
      end
      if (pv) begin
        if (occ < DEPTH || popped) mq.push_back({pa, pt});
        else m_ovf = 1'b1;
      end
    end
    if (e) begin
      if (fl > 0) fl--;
      if (mis) begin fl = FC; mq.delete(); end
    end
    @(posedge clk); #1;
    chk("upd_en", upd_en, exp_upd);
    if (upd_en === 1'b1) begin
      if (sb.size() == 0) chk("sb_nonempty", 0, 1);
      else begin
        u = sb.pop_front();
        chk("upd_addr", upd_addr, u.addr);
        chk("upd_taken", upd_taken, u.taken);
        chk("redirect_valid", redirect_valid, u.redir);
        if (u.redir) chk("redirect_pc", redirect_pc, u.pc);
      end
    end else begin
      chk("redirect_idle", redirect_valid, 0);
    end
    chk("underflow", underflow, exp_unf);
    chk("flush", flush, fl > 0);
    chk("full", full, mq.size() == DEPTH);
    chk("overflow", overflow, m_ovf);
    chk("branch_cnt", branch_cnt, m_bcnt);
    chk("mispredict_cnt", mispredict_cnt, m_mcnt);
  endtask

  task automatic idle();
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic push(input logic [4:0] a, input logic p);
    cyc(1, 1, a, p, 0, 0, 0, 0, 0);
  endtask

  task automatic rst();
    arst_n = 1'b0; en = 1'b0; pred_valid = 1'b0; res_valid = 1'b0;
    #4;
    model_reset();
    chk("rst_full", full, 0);
    chk("rst_overflow", overflow, 0);
    arst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    #2;
    chk("reset_upd_en", upd_en, 0);
    chk("reset_upd_addr", upd_addr, 0);
    chk("reset_upd_taken", upd_taken, 0);
    chk("reset_flush", flush, 0);
    chk("reset_redirect_valid", redirect_valid, 0);
    chk("reset_redirect_pc", redirect_pc, 0);
    chk("reset_full", full, 0);
    chk("reset_overflow", overflow, 0);
    chk("reset_underflow", underflow, 0);
    chk("reset_branch_cnt", branch_cnt, 0);
    chk("reset_mispredict_cnt", mispredict_cnt, 0);
    #10 arst_n = 1'b1;

    // Correct taken prediction: update only
    push(3, 1);
    cyc(1, 0, 0, 0, 1, 1, 0, 32'h100, 32'h20);
    idle();

    // Taken mispredict: redirect to target, flush, queue cleared
    push(7, 0);
    push(9, 1);
    cyc(1, 0, 0, 0, 1, 1, 0, 32'h40, 32'h24);
    cyc(1, 1, 11, 1, 1, 1, 0, 32'h80, 32'h84);   // ignored during flush
    idle();
    // Resolve on an empty queue
    cyc(1, 0, 0, 0, 1, 0, 0, 32'h0, 32'h0);
    idle();

    // Overflow: five pushes, four resolves in order
    rst();
    for (int i = 1; i <= 5; i++) push(5'(i), i[0]);
    for (int i = 1; i <= 4; i++) cyc(1, 0, 0, 0, 1, i[0], 0, 32'h0, 32'h0);
    idle();

    // Full queue with simultaneous push and pop, pointers wrap
    rst();
    for (int i = 10; i <= 13; i++) push(5'(i), 0);
    cyc(1, 1, 14, 1, 1, 0, 0, 32'h0, 32'h0);
    cyc(1, 1, 15, 1, 1, 0, 0, 32'h0, 32'h0);
    cyc(1, 0, 0, 0, 1, 0, 0, 32'h0, 32'h0);
    cyc(1, 0, 0, 0, 1, 0, 0, 32'h0, 32'h0);
    cyc(1, 0, 0, 0, 1, 0, 1, 32'h300, 32'h0);      // jump, predicted taken
    cyc(1, 0, 0, 0, 1, 0, 0, 32'h90, 32'h88);     // not-taken mispredict
    idle();
    idle();

    // Stall: nothing is taken in with en low
    cyc(0, 1, 5, 1, 1, 1, 0, 32'h0, 32'h0);
    cyc(1, 0, 0, 0, 1, 0, 0, 32'h0, 32'h0);
    idle();

    // Reset during the first flush cycle
    push(2, 0);
    cyc(1, 0, 0, 0, 1, 1, 0, 32'h200, 32'h204);
    arst_n = 1'b0;
    #1;
    chk("arst_flush", flush, 0);
    chk("arst_redirect", redirect_valid, 0);
    #2;
    model_reset();
    arst_n = 1'b1;
    idle();
    idle();
    push(4, 1);
    cyc(1, 0, 0, 0, 1, 1, 0, 32'h10, 32'h14);
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule
